// File: rtl/dsm_integ_stage_mc.sv
// Time-multiplexed multi-channel delta-sigma integrator stage.
// One channel per cycle from a per-frame input snapshot, with optional saturation and output gain.
module dsm_integ_stage_mc #(
  parameter int W       = 36,
  parameter int NCH     = 4,
  parameter int CGAIN   = 0,
  parameter int DELAYED = 0,
  parameter int SAT     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fs_enb,
  input  logic [NCH*W-1:0] inpb,
  input  logic [NCH*W-1:0] outa,
  input  logic [NCH*W-1:0] csump,
  input  logic [NCH*W-1:0] gsum,
  input  logic             clr_ovf,
  output logic [NCH*W-1:0] csum,
  output logic             csum_vld,
  output logic             busy,
  output logic [NCH-1:0]   ovf,
  output logic             miss
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
  localparam logic signed [W+2:0] ACC_MAX = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] ACC_MIN = {4'b1111, {(W-1){1'b0}}};
  localparam logic [W-1:0] ST_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ST_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e             fsm_q, fsm_d;
  logic [CW-1:0]      ch_q, ch_d;
  logic [NCH*W-1:0]   snap_inpb_q, snap_inpb_d;
  logic [NCH*W-1:0]   snap_outa_q, snap_outa_d;
  logic [NCH*W-1:0]   snap_csump_q, snap_csump_d;
  logic [NCH*W-1:0]   snap_gsum_q, snap_gsum_d;
  logic [NCH*W-1:0]   state_q, state_d;
  logic [NCH*W-1:0]   csum_q, csum_d;
  logic [NCH-1:0]     ovf_q, ovf_d;
  logic               miss_q, miss_d;

  logic signed [W-1:0] st_old, st_new, csum_sel, csum_ch;
  logic signed [W+1:0] xin;
  logic signed [W+2:0] acc;
  logic                clip_hi, clip_lo;
  logic [NCH-1:0]      ovf_set;
  logic                miss_set;

  function automatic logic [W+1:0] sx2(input logic [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      ch_q         <= '0;
      snap_inpb_q  <= '0;
      snap_outa_q  <= '0;
      snap_csump_q <= '0;
      snap_gsum_q  <= '0;
      state_q      <= '0;
      csum_q       <= '0;
      ovf_q        <= '0;
      miss_q       <= '0;
    end else begin
      fsm_q        <= fsm_d;
      ch_q         <= ch_d;
      snap_inpb_q  <= snap_inpb_d;
      snap_outa_q  <= snap_outa_d;
      snap_csump_q <= snap_csump_d;
      snap_gsum_q  <= snap_gsum_d;
      state_q      <= state_d;
      csum_q       <= csum_d;
      ovf_q        <= ovf_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (fs_enb) fsm_d = RUN;
      RUN:     if (ch_q == CH_LAST) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (fsm_q != IDLE);
    csum_vld = (fsm_q == DONE);
  end

  // Sum of four W-bit terms needs two guard bits; adding state needs one more.
  always_comb begin
    st_old  = state_q[ch_q*W +: W];
    xin     = sx2(snap_inpb_q[ch_q*W +: W]) + sx2(snap_outa_q[ch_q*W +: W])
            + sx2(snap_csump_q[ch_q*W +: W]) + sx2(snap_gsum_q[ch_q*W +: W]);
    acc     = {{3{st_old[W-1]}}, st_old} + {xin[W+1], xin};
    clip_hi = (acc > ACC_MAX);
    clip_lo = (acc < ACC_MIN);
    if (SAT != 0 && clip_hi)      st_new = ST_MAX;
    else if (SAT != 0 && clip_lo) st_new = ST_MIN;
    else                          st_new = acc[W-1:0];
    csum_sel = (DELAYED != 0) ? st_old : st_new;
    csum_ch  = csum_sel >>> CGAIN;
  end

  always_comb begin
    ch_d         = ch_q;
    snap_inpb_d  = snap_inpb_q;
    snap_outa_d  = snap_outa_q;
    snap_csump_d = snap_csump_q;
    snap_gsum_d  = snap_gsum_q;
    state_d      = state_q;
    csum_d       = csum_q;
    ovf_set      = '0;
    unique case (fsm_q)
      IDLE: begin
        if (fs_enb) begin
          ch_d         = '0;
          snap_inpb_d  = inpb;
          snap_outa_d  = outa;
          snap_csump_d = csump;
          snap_gsum_d  = gsum;
        end
      end
      RUN: begin
        state_d[ch_q*W +: W] = st_new;
        csum_d[ch_q*W +: W]  = csum_ch;
        ovf_set[ch_q]        = clip_hi | clip_lo;
        ch_d                 = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
      end
      default: ;
    endcase
    miss_set = fs_enb && (fsm_q != IDLE);
    ovf_d    = (clr_ovf ? '0 : ovf_q) | ovf_set;
    miss_d   = (clr_ovf ? 1'b0 : miss_q) | miss_set;
  end

  assign csum = csum_q;
  assign ovf  = ovf_q;
  assign miss = miss_q;

endmodule

// File: tb/tb_dsm_integ_stage_mc.sv
// Bench for dsm_integ_stage_mc: four variants (base, delaying, wrapping, gain=2) share stimulus;
// a behavioural model pushes expected frames to a scoreboard popped on csum_vld.
module tb_dsm_integ_stage_mc;
  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int NI  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, fs_enb = 1'b0, clr_ovf = 1'b0;
  logic [NCH*W-1:0] inpb = '0, outa = '0, csump = '0, gsum = '0;
  logic [NCH*W-1:0] csum_o [NI];
  logic [NI-1:0]  vld_o, busy_o, miss_o;
  logic [NCH-1:0] ovf_o [NI];

  int n_cmp = 0, n_bad = 0;

  typedef struct packed { logic [NI*NCH*W-1:0] cs; logic [NI*NCH-1:0] ov; } exp_t;
  exp_t sb[$];

  int p_dly [NI] = '{0, 1, 0, 0};
  int p_sat [NI] = '{1, 1, 0, 1};
  int p_cg  [NI] = '{0, 0, 0, 2};
  int mst [NI][NCH];
  logic [NCH*W-1:0] mcs [NI];
  logic [NCH-1:0]   movf [NI];
  logic             mmiss;
  int in_v [NCH][4];

  dsm_integ_stage_mc #(.W(W), .NCH(NCH), .CGAIN(0), .DELAYED(0), .SAT(1)) u_base (
    .clk(clk), .rst(rst), .fs_enb(fs_enb), .inpb(inpb), .outa(outa), .csump(csump), .gsum(gsum),
    .clr_ovf(clr_ovf), .csum(csum_o[0]), .csum_vld(vld_o[0]), .busy(busy_o[0]), .ovf(ovf_o[0]), .miss(miss_o[0]));
  dsm_integ_stage_mc #(.W(W), .NCH(NCH), .CGAIN(0), .DELAYED(1), .SAT(1)) u_dly (
    .clk(clk), .rst(rst), .fs_enb(fs_enb), .inpb(inpb), .outa(outa), .csump(csump), .gsum(gsum),
    .clr_ovf(clr_ovf), .csum(csum_o[1]), .csum_vld(vld_o[1]), .busy(busy_o[1]), .ovf(ovf_o[1]), .miss(miss_o[1]));
  dsm_integ_stage_mc #(.W(W), .NCH(NCH), .CGAIN(0), .DELAYED(0), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .fs_enb(fs_enb), .inpb(inpb), .outa(outa), .csump(csump), .gsum(gsum),
    .clr_ovf(clr_ovf), .csum(csum_o[2]), .csum_vld(vld_o[2]), .busy(busy_o[2]), .ovf(ovf_o[2]), .miss(miss_o[2]));
  dsm_integ_stage_mc #(.W(W), .NCH(NCH), .CGAIN(2), .DELAYED(0), .SAT(1)) u_gain (
    .clk(clk), .rst(rst), .fs_enb(fs_enb), .inpb(inpb), .outa(outa), .csump(csump), .gsum(gsum),
    .clr_ovf(clr_ovf), .csum(csum_o[3]), .csum_vld(vld_o[3]), .busy(busy_o[3]), .ovf(ovf_o[3]), .miss(miss_o[3]));

  task automatic set_in(input int c, input int a, input int b, input int d, input int e);
    in_v[c][0] = a; in_v[c][1] = b; in_v[c][2] = d; in_v[c][3] = e;
    inpb[c*W +: W]  = W'(a);
    outa[c*W +: W]  = W'(b);
    csump[c*W +: W] = W'(d);
    gsum[c*W +: W]  = W'(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NCH; c++) mst[k][c] = 0;
      mcs[k] = '0; movf[k] = '0;
    end
    mmiss = 1'b0;
    sb.delete();
  endtask

  task automatic model_frame();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < NCH; c++) begin
        int x, old, acc, nw, sel;
        x   = in_v[c][0] + in_v[c][1] + in_v[c][2] + in_v[c][3];
        old = mst[k][c];
        acc = old + x;
        if (p_sat[k] != 0) nw = (acc > 127) ? 127 : ((acc < -128) ? -128 : acc);
        else begin
          nw = acc & 255;
          if (nw > 127) nw -= 256;
        end
        if (acc > 127 || acc < -128) movf[k][c] = 1'b1;
        mst[k][c] = nw;
        sel = (p_dly[k] != 0) ? old : nw;
        sel = sel >>> p_cg[k];
        mcs[k][c*W +: W] = W'(sel);
      end
      e.cs[k*NCH*W +: NCH*W] = mcs[k];
      e.ov[k*NCH +: NCH]     = movf[k];
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic start_frame();
    @(negedge clk); fs_enb = 1'b1; model_frame();
    @(negedge clk); fs_enb = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (vld_o[0] !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; fs_enb = 1'b1; clr_ovf = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0; fs_enb = 1'b0; clr_ovf = 1'b0;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      n_cmp++; if (csum_o[k] !== '0) begin n_bad++; $display("FAIL reset_csum[%0d]: got %h want 0", k, csum_o[k]); end
      n_cmp++; if (ovf_o[k] !== '0) begin n_bad++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf_o[k]); end
    end
    n_cmp++; if (busy_o !== '0 || vld_o !== '0 || miss_o !== '0) begin
      n_bad++; $display("FAIL reset_ctrl: busy %b vld %b miss %b want all 0", busy_o, vld_o, miss_o);
    end
  endtask

  task automatic test_integrate();
    int lat; exp_t e;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      set_in(0, 1, 2, 3, 4); set_in(1, 0, 0, 0, 0);
      start_frame();
      n_cmp++; if (busy_o !== '1) begin n_bad++; $display("FAIL integ_busy: got %b want 1111", busy_o); end
      inpb = '1; outa = '1; csump = 16'h5a5a; gsum = 16'h7f7f;
      wait_vld(lat);
      n_cmp++; if (lat != NCH) begin n_bad++; $display("FAIL integ_latency f%0d: got %0d want %0d", f, lat, NCH); end
      n_cmp++; if (vld_o !== '1) begin n_bad++; $display("FAIL integ_vld_all f%0d: got %b want 1111", f, vld_o); end
      e = sb.pop_front();
      for (int k = 0; k < NI; k++) begin
        n_cmp++; if (csum_o[k] !== e.cs[k*NCH*W +: NCH*W]) begin
          n_bad++; $display("FAIL integ_csum f%0d inst%0d: got %h want %h", f, k, csum_o[k], e.cs[k*NCH*W +: NCH*W]);
        end
      end
      n_cmp++; if ($signed(csum_o[0][7:0]) != ((f == 0) ? 10 : 20)) begin
        n_bad++; $display("FAIL integ_base_ch0 f%0d: got %0d want %0d", f, $signed(csum_o[0][7:0]), (f == 0) ? 10 : 20);
      end
      n_cmp++; if ($signed(csum_o[1][7:0]) != ((f == 0) ? 0 : 10)) begin
        n_bad++; $display("FAIL integ_dly_ch0 f%0d: got %0d want %0d", f, $signed(csum_o[1][7:0]), (f == 0) ? 0 : 10);
      end
      @(negedge clk);
      n_cmp++; if (vld_o !== '0) begin n_bad++; $display("FAIL integ_vld_pulse f%0d: got %b want 0000", f, vld_o); end
      inpb = '0; outa = '0; csump = '0; gsum = '0;
      @(negedge clk);
      n_cmp++; if (csum_o[0] !== e.cs[NCH*W-1:0] || busy_o !== '0) begin
        n_bad++; $display("FAIL integ_hold f%0d: got %h busy %b want %h busy 0", f, csum_o[0], busy_o, e.cs[NCH*W-1:0]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat; exp_t e;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      if (f == 0) set_in(0, 30, 30, 30, 30); else set_in(0, 5, 5, 5, 5);
      set_in(1, 0, 0, 0, 0);
      start_frame();
      wait_vld(lat);
      n_cmp++; if (lat != NCH) begin n_bad++; $display("FAIL sat_latency f%0d: got %0d want %0d", f, lat, NCH); end
      e = sb.pop_front();
      for (int k = 0; k < NI; k++) begin
        n_cmp++; if (csum_o[k] !== e.cs[k*NCH*W +: NCH*W]) begin
          n_bad++; $display("FAIL sat_csum f%0d inst%0d: got %h want %h", f, k, csum_o[k], e.cs[k*NCH*W +: NCH*W]);
        end
        n_cmp++; if (ovf_o[k] !== e.ov[k*NCH +: NCH]) begin
          n_bad++; $display("FAIL sat_ovf f%0d inst%0d: got %b want %b", f, k, ovf_o[k], e.ov[k*NCH +: NCH]);
        end
      end
    end
    n_cmp++; if (csum_o[0][7:0] !== 8'h7f) begin n_bad++; $display("FAIL sat_clamp: got %h want 7f", csum_o[0][7:0]); end
    n_cmp++; if (csum_o[2][7:0] !== 8'h8c) begin n_bad++; $display("FAIL wrap_value: got %h want 8c", csum_o[2][7:0]); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    for (int k = 0; k < NI; k++) begin
      movf[k] = '0;
      n_cmp++; if (ovf_o[k] !== '0) begin n_bad++; $display("FAIL sat_clr_ovf inst%0d: got %b want 00", k, ovf_o[k]); end
    end
  endtask

  task automatic test_gain();
    int lat; exp_t e;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      set_in(0, 0, 0, 0, 0);
      if (f == 0) set_in(1, -5, -5, -5, -5); else set_in(1, 10, 10, 10, 10);
      start_frame();
      wait_vld(lat);
      n_cmp++; if (lat != NCH) begin n_bad++; $display("FAIL gain_latency f%0d: got %0d want %0d", f, lat, NCH); end
      e = sb.pop_front();
      for (int k = 0; k < NI; k++) begin
        n_cmp++; if (csum_o[k] !== e.cs[k*NCH*W +: NCH*W]) begin
          n_bad++; $display("FAIL gain_csum f%0d inst%0d: got %h want %h", f, k, csum_o[k], e.cs[k*NCH*W +: NCH*W]);
        end
      end
      n_cmp++; if ($signed(csum_o[3][15:8]) != ((f == 0) ? -5 : 5)) begin
        n_bad++; $display("FAIL gain_ch1 f%0d: got %0d want %0d", f, $signed(csum_o[3][15:8]), (f == 0) ? -5 : 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nv; exp_t e;
    do_reset();
    set_in(0, 1, 2, 3, 4); set_in(1, 7, 0, 0, -1);
    start_frame();
    fs_enb = 1'b1; mmiss = 1'b1;
    @(negedge clk); fs_enb = 1'b0;
    n_cmp++; if (miss_o !== '1) begin n_bad++; $display("FAIL b2b_miss: got %b want 1111", miss_o); end
    wait_vld(lat);
    n_cmp++; if (lat != NCH - 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, NCH - 1); end
    e = sb.pop_front();
    for (int k = 0; k < NI; k++) begin
      n_cmp++; if (csum_o[k] !== e.cs[k*NCH*W +: NCH*W]) begin
        n_bad++; $display("FAIL b2b_csum inst%0d: got %h want %h", k, csum_o[k], e.cs[k*NCH*W +: NCH*W]);
      end
    end
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld_o[0] === 1'b1) nv++;
    end
    n_cmp++; if (nv != 0 || busy_o !== '0) begin n_bad++; $display("FAIL b2b_single_vld: extra %0d busy %b want 0 0", nv, busy_o); end
    clr_ovf = 1'b1; mmiss = 1'b0;
    @(negedge clk); clr_ovf = 1'b0;
    n_cmp++; if (miss_o !== {NI{mmiss}}) begin n_bad++; $display("FAIL b2b_clr_miss: got %b want 0000", miss_o); end
  endtask

  task automatic test_reset_midframe();
    int lat, nv; exp_t e;
    do_reset();
    set_in(0, 1, 2, 3, 4); set_in(1, 3, 3, 3, 3);
    start_frame();
    wait_vld(lat);
    void'(sb.pop_front());
    @(negedge clk);
    start_frame();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      n_cmp++; if (csum_o[k] !== '0) begin n_bad++; $display("FAIL abort_csum inst%0d: got %h want 0", k, csum_o[k]); end
    end
    n_cmp++; if (busy_o !== '0 || vld_o !== '0) begin n_bad++; $display("FAIL abort_ctrl: busy %b vld %b want 0", busy_o, vld_o); end
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vld_o[0] === 1'b1) nv++;
    end
    n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL abort_no_vld: got %0d pulses want 0", nv); end
    set_in(1, 0, 0, 0, 0);
    start_frame();
    wait_vld(lat);
    n_cmp++; if (lat != NCH) begin n_bad++; $display("FAIL abort_latency: got %0d want %0d", lat, NCH); end
    e = sb.pop_front();
    n_cmp++; if (csum_o[0] !== e.cs[NCH*W-1:0] || $signed(csum_o[0][7:0]) != 10) begin
      n_bad++; $display("FAIL abort_restart: got %h want %h (ch0=10)", csum_o[0], e.cs[NCH*W-1:0]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_integrate();
    test_saturation();
    test_gain();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsm_integ_stage_mc.md
DSM_INTEG_STAGE_MC -- requirements
Module: dsm_integ_stage_mc

Interface
REQ-001 Parameter W, default 36, sample/state width in bits, two's complement.
REQ-002 Parameter NCH, default 4, number of time-multiplexed channels (1..16).
REQ-003 Parameter CGAIN, default 0, output gain as arithmetic right shift by CGAIN (0..W-1).
REQ-004 Parameter DELAYED, default 0: 0 = non-delaying integrator (csum from updated state), 1 = delaying (csum from pre-update state).
REQ-005 Parameter SAT, default 1: 1 = saturate state at W-bit limits, 0 = wrap.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 fs_enb  in  1  sample-rate strobe, starts one frame.
REQ-010 inpb, outa, csump, gsum  in  NCH*W each  packed per-channel terms; channel c at bits [c*W +: W].
REQ-011 clr_ovf  in  1  clears ovf and miss.
REQ-012 csum  out  NCH*W  packed scaled integrator outputs, same packing.
REQ-013 csum_vld  out  1  one-cycle pulse, all csum channels updated for the frame.
REQ-014 busy  out  1  high while a frame is in progress.
REQ-015 ovf  out  NCH  sticky per-channel overflow flags.
REQ-016 miss  out  1  sticky flag, fs_enb arrived while busy.

Function
REQ-017 FSM states IDLE, RUN, DONE; IDLE + fs_enb -> RUN with channel counter ch=0 and all four input buses snapshotted into internal registers.
REQ-018 Each RUN cycle processes channel ch only, using snapshot values; later input changes do not affect the frame.
REQ-019 xin = inpb[ch]+outa[ch]+csump[ch]+gsum[ch], sign-extended, computed at W+2 bits without loss.
REQ-020 acc = state[ch] + xin at W+3 bits.
REQ-021 SAT=1: new state = acc clamped to [-2^(W-1), 2^(W-1)-1]; ovf[ch] set when clamping occurs.
REQ-022 SAT=0: new state = acc[W-1:0]; ovf[ch] set when truncation changes the value.
REQ-023 csum[ch] <= (DELAYED ? old state[ch] : new state) >>> CGAIN, sign-preserving; registered in the same cycle as the state write.
REQ-024 ch increments each RUN cycle; after ch=NCH-1 FSM -> DONE.
REQ-025 DONE: csum_vld=1 for exactly one cycle, then -> IDLE; busy=1 in RUN and DONE, 0 in IDLE.
REQ-026 Latency: fs_enb sampled at cycle t -> csum_vld high at cycle t+NCH+1; minimum frame spacing NCH+2 cycles.
REQ-027 fs_enb while busy is ignored (no restart, no state change) and sets miss.
REQ-028 csum channels not yet processed in a frame hold previous-frame values; all csum hold between frames.
REQ-029 clr_ovf clears ovf and miss; a set event in the same cycle wins.
REQ-030 State storage is one W-bit register per channel; no state shared across channels.

Reset
REQ-031 rst: all state[] = 0, csum = 0, csum_vld = 0, busy = 0, ovf = 0, miss = 0, FSM = IDLE, ch = 0.
REQ-032 rst mid-frame aborts the frame; no csum_vld issued; next fs_enb after rst release starts a clean frame.
REQ-033 rst has priority over fs_enb and clr_ovf in the same cycle.

Verification (W=8, NCH=2 unless stated)
REQ-034 DELAYED=0, CGAIN=0, ch0 inputs 1,2,3,4, ch1 all 0, two frames -> ch0 csum 10 then 20, ch1 0, csum_vld at t+3 each frame.
REQ-035 DELAYED=1, same stimulus -> ch0 csum 0 after frame 1, 10 after frame 2.
REQ-036 SAT=1, state ch0=120, xin=20 -> csum 127, ovf[0]=1; clr_ovf -> ovf=0; SAT=0 same case -> csum -116, ovf[0]=1.
REQ-037 CGAIN=2, ch1 state reaching -20 -> csum ch1 = -5; state +20 -> 5.
REQ-038 fs_enb re-asserted one cycle after frame start -> ignored, miss=1, exactly one csum_vld, states advanced once.
REQ-039 rst asserted during RUN with ch=1 -> next cycle all outputs 0, busy=0, no csum_vld; following frame reproduces REQ-034 frame-1 values.
